// File: rtl/mult_v2_coe_ctrl_if.sv
// Host-side bus of the mult_v2 coefficient controller: shadow write/read
// port, commit request and status.
interface mult_v2_coe_ctrl_if #(
    parameter int unsigned COE_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  wr_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [COE_WIDTH-1:0]  data_i;
    logic                  commit_i;
    logic                  rd_i;
    logic [COE_WIDTH-1:0]  rdata_o;
    logic                  busy_o;
    logic                  wr_err_o;

    // Host side drives requests, observes status.
    modport master (
        output wr_i, addr_i, data_i, commit_i, rd_i,
        input  rdata_o, busy_o, wr_err_o
    );

    // Controller side.
    modport slave (
        input  wr_i, addr_i, data_i, commit_i, rd_i,
        output rdata_o, busy_o, wr_err_o
    );
endinterface

// File: rtl/mult_v2_coe_ctrl.sv
// Coefficient controller for the mult_v2 3x3 colour matrix. A host-writable
// shadow bank is copied atomically into the active bank, but only while the
// stream is in vertical blanking, so no frame sees a mixed coefficient set.
// Optional shadow readback is built when MULT_COE_CTRL_RDBK_EN is defined.
module mult_v2_coe_ctrl #(
    parameter int unsigned COE_WIDTH  = 16,
    parameter int unsigned COE_COUNT  = 9,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FCNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    mult_v2_coe_ctrl_if.slave              hst,
    input  logic                           vs_i,
    output logic [COE_WIDTH*COE_COUNT-1:0] coe_o,
    output logic                           upd_o,
    output logic [FCNT_WIDTH-1:0]          frame_cnt_o
);

    localparam logic [COE_WIDTH-1:0]  CoeOne = COE_WIDTH'(1024);  // Q4.10 1.0
    localparam logic [ADDR_WIDTH:0]   CoeCnt = (ADDR_WIDTH+1)'(COE_COUNT);

    typedef enum logic [1:0] {StIdle, StPend, StApply} state_e;

    // Identity matrix element: diagonal of the row-major 3x3.
    function automatic logic [COE_WIDTH-1:0] ident(input int unsigned k);
        return ((k / 3) == (k % 3)) ? CoeOne : '0;
    endfunction

    state_e                           state_q, state_d;
    logic [COE_WIDTH-1:0]             shadow_q [COE_COUNT];
    logic [COE_WIDTH*COE_COUNT-1:0]   coe_q;
    logic                             upd_q;
    logic                             wr_err_q;
    logic                             vs_q;
    logic [FCNT_WIDTH-1:0]            frame_cnt_q;
    logic                             addr_ok;
    logic                             busy;
    logic                             apply_go;

    assign addr_ok = ({1'b0, hst.addr_i} < CoeCnt);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: commit waits in PEND until blanking, APPLY aborts on frame start.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (hst.commit_i) state_d = StPend;
            StPend:  if (!vs_i) state_d = StApply;
            StApply: begin
                if (vs_i) begin
                    state_d = StPend;
                end else begin
                    state_d = hst.commit_i ? StPend : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy     = (state_q != StIdle);
        apply_go = (state_q == StApply) && !vs_i;
    end

    // Shadow bank; writes accepted in every state. Active bank snapshots the
    // pre-edge shadow, so a write in the APPLY cycle only reaches shadow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < COE_COUNT; k++) begin
                shadow_q[k]                          <= ident(k);
                coe_q[k*COE_WIDTH +: COE_WIDTH]      <= ident(k);
            end
        end else begin
            if (hst.wr_i && addr_ok) begin
                shadow_q[hst.addr_i] <= hst.data_i;
            end
            if (apply_go) begin
                for (int unsigned k = 0; k < COE_COUNT; k++) begin
                    coe_q[k*COE_WIDTH +: COE_WIDTH] <= shadow_q[k];
                end
            end
        end
    end

    // Status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_q    <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            upd_q    <= apply_go;
            wr_err_q <= hst.wr_i && !addr_ok;
        end
    end

    // Frame counter on vs_i falling edges, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_q        <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            vs_q <= vs_i;
            if (vs_q && !vs_i) begin
                frame_cnt_q <= frame_cnt_q + FCNT_WIDTH'(1);
            end
        end
    end

`ifdef MULT_COE_CTRL_RDBK_EN
    logic [COE_WIDTH-1:0] rdata_q;

    // Shadow readback register; holds between reads, out-of-range reads 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (hst.rd_i) begin
            rdata_q <= addr_ok ? shadow_q[hst.addr_i] : '0;
        end
    end

    assign hst.rdata_o = rdata_q;
`else
    logic unused_rd;
    assign unused_rd   = hst.rd_i;
    assign hst.rdata_o = '0;
`endif

    assign coe_o        = coe_q;
    assign upd_o        = upd_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign hst.busy_o   = busy;
    assign hst.wr_err_o = wr_err_q;

endmodule

// File: tb/tb_mult_v2_coe_ctrl.sv
// Directed bench for mult_v2_coe_ctrl: a per-cycle vector table plus
// hand-written reset-mid-commit and readback sequences.
module tb_mult_v2_coe_ctrl;

    localparam int unsigned CW = 16;
    localparam int unsigned CN = 9;
    localparam int unsigned AW = 4;
    localparam int unsigned FW = 16;
    localparam int unsigned NV = 25;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        commit;
        logic        vs;
        int unsigned k;
        logic [15:0] coe;
        logic        upd;
        logic        busy;
        logic        err;
        logic [15:0] fcnt;
    } vec_t;

    logic              clk;
    logic              rst;
    logic              vs_i;
    logic [CW*CN-1:0]  coe;
    logic              upd;
    logic [FW-1:0]     fcnt;
    int                checks;
    int                failures;
    vec_t              vec [NV];

    mult_v2_coe_ctrl_if #(.COE_WIDTH(CW), .ADDR_WIDTH(AW)) hif ();

    mult_v2_coe_ctrl #(
        .COE_WIDTH (CW),
        .COE_COUNT (CN),
        .ADDR_WIDTH(AW),
        .FCNT_WIDTH(FW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hst        (hif.slave),
        .vs_i       (vs_i),
        .coe_o      (coe),
        .upd_o      (upd),
        .frame_cnt_o(fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] elem(input int unsigned k);
        return coe[k*CW +: CW];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic wr, input logic [3:0] addr, input logic [15:0] data,
                        input logic commit, input logic rd, input logic vs);
        hif.wr_i     = wr;
        hif.addr_i   = addr;
        hif.data_i   = data;
        hif.commit_i = commit;
        hif.rd_i     = rd;
        vs_i         = vs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] idv;
        bit          seen;
        checks   = 0;
        failures = 0;

        //            wr    addr   data      cmt   vs    k  coe       upd   busy  err   fcnt
        vec[0]  = '{1'b1, 4'd1,  16'hFC00, 1'b0, 1'b0, 1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0};
        vec[1]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd0};
        vec[2]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd0};
        vec[3]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1, 16'hFC00, 1'b1, 1'b0, 1'b0, 16'd0};
        vec[4]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1, 16'hFC00, 1'b0, 1'b0, 1'b0, 16'd0};
        vec[5]  = '{1'b1, 4'd8,  16'h0800, 1'b0, 1'b1, 8, 16'h0400, 1'b0, 1'b0, 1'b0, 16'd0};
        vec[6]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 1'b1, 8, 16'h0400, 1'b0, 1'b1, 1'b0, 16'd0};
        vec[7]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 1'b1, 8, 16'h0400, 1'b0, 1'b1, 1'b0, 16'd0};
        vec[8]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b1, 8, 16'h0400, 1'b0, 1'b1, 1'b0, 16'd0};
        vec[9]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 8, 16'h0400, 1'b0, 1'b1, 1'b0, 16'd1};
        vec[10] = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 8, 16'h0800, 1'b1, 1'b0, 1'b0, 16'd1};
        vec[11] = '{1'b1, 4'd9,  16'hFFFF, 1'b0, 1'b0, 8, 16'h0800, 1'b0, 1'b0, 1'b1, 16'd1};
        vec[12] = '{1'b1, 4'd15, 16'h1111, 1'b0, 1'b0, 8, 16'h0800, 1'b0, 1'b0, 1'b1, 16'd1};
        vec[13] = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 8, 16'h0800, 1'b0, 1'b0, 1'b0, 16'd1};
        vec[14] = '{1'b1, 4'd0,  16'h0200, 1'b1, 1'b0, 0, 16'h0400, 1'b0, 1'b1, 1'b0, 16'd1};
        vec[15] = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 0, 16'h0400, 1'b0, 1'b1, 1'b0, 16'd1};
        vec[16] = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b1, 0, 16'h0400, 1'b0, 1'b1, 1'b0, 16'd1};
        vec[17] = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b1, 0, 16'h0400, 1'b0, 1'b1, 1'b0, 16'd1};
        vec[18] = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 0, 16'h0400, 1'b0, 1'b1, 1'b0, 16'd2};
        vec[19] = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 0, 16'h0200, 1'b1, 1'b0, 1'b0, 16'd2};
        vec[20] = '{1'b1, 4'd2,  16'h0111, 1'b1, 1'b0, 2, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd2};
        vec[21] = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 2, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd2};
        vec[22] = '{1'b1, 4'd2,  16'h0222, 1'b1, 1'b0, 2, 16'h0111, 1'b1, 1'b1, 1'b0, 16'd2};
        vec[23] = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 2, 16'h0111, 1'b0, 1'b1, 1'b0, 16'd2};
        vec[24] = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 2, 16'h0222, 1'b1, 1'b0, 1'b0, 16'd2};

        // Reset and check identity state.
        rst          = 1'b0;
        hif.wr_i     = 1'b0;
        hif.addr_i   = '0;
        hif.data_i   = '0;
        hif.commit_i = 1'b0;
        hif.rd_i     = 1'b0;
        vs_i         = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 9; k++) begin
            idv = (k == 0 || k == 4 || k == 8) ? 16'h0400 : 16'h0000;
            check($sformatf("reset coe[%0d]", k), 32'(elem(k)), 32'(idv));
        end
        check("reset busy", 32'(hif.busy_o), 32'd0);
        check("reset upd", 32'(upd), 32'd0);
        check("reset wr_err", 32'(hif.wr_err_o), 32'd0);
        check("reset frame_cnt", 32'(fcnt), 32'd0);
        check("reset rdata", 32'(hif.rdata_o), 32'd0);

        // Vector table.
        for (int i = 0; i < NV; i++) begin
            step(vec[i].wr, vec[i].addr, vec[i].data, vec[i].commit, 1'b0, vec[i].vs);
            check($sformatf("row%0d coe[%0d]", i, vec[i].k), 32'(elem(vec[i].k)), 32'(vec[i].coe));
            check($sformatf("row%0d upd", i), 32'(upd), 32'(vec[i].upd));
            check($sformatf("row%0d busy", i), 32'(hif.busy_o), 32'(vec[i].busy));
            check($sformatf("row%0d wr_err", i), 32'(hif.wr_err_o), 32'(vec[i].err));
            check($sformatf("row%0d frame_cnt", i), 32'(fcnt), 32'(vec[i].fcnt));
        end
        check("bad-addr writes left coe[1]", 32'(elem(1)), 32'hFC00);

        // Reset asserted while in APPLY: commit abandoned, banks back to identity.
        step(1'b1, 4'd1, 16'h0123, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #2;
        check("midreset coe[0]", 32'(elem(0)), 32'h0400);
        check("midreset coe[1]", 32'(elem(1)), 32'h0000);
        check("midreset coe[2]", 32'(elem(2)), 32'h0000);
        check("midreset busy", 32'(hif.busy_o), 32'd0);
        check("midreset frame_cnt", 32'(fcnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        check("postreset upd", 32'(upd), 32'd0);

        // Commit after reset must copy the identity shadow, not the lost write.
        step(1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
            if (upd) seen = 1'b1;
        end
        check("postreset upd seen", 32'(seen), 32'd1);
        check("postreset coe[1]", 32'(elem(1)), 32'h0000);
        check("postreset coe[8]", 32'(elem(8)), 32'h0400);

        // Shadow readback.
        step(1'b1, 4'd4, 16'h1234, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd4, 16'h0000, 1'b0, 1'b1, 1'b0);
`ifdef MULT_COE_CTRL_RDBK_EN
        check("rdbk k4", 32'(hif.rdata_o), 32'h1234);
        check("rdbk coe[4] unchanged", 32'(elem(4)), 32'h0400);
        step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("rdbk k0", 32'(hif.rdata_o), 32'h0400);
        step(1'b0, 4'd9, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("rdbk bad addr", 32'(hif.rdata_o), 32'h0000);
        step(1'b0, 4'd4, 16'h0000, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("rdbk hold", 32'(hif.rdata_o), 32'h1234);
`else
        check("rdata tied off", 32'(hif.rdata_o), 32'h0000);
        check("coe[4] unchanged", 32'(elem(4)), 32'h0400);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
